// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state
// encoding, wait-counter width and the word-index width helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int word_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_ram_sp.sv
// Single-port word RAM with synchronous write and registered read.
// Contents are intentionally not reset.
module ram_sp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array write port and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Word read/write responder with a fixed wait latency and one-cycle ack.
// Optional misaligned-access detection is enabled by DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  err
);

  localparam int   IDX_W = word_idx_w(DEPTH);
  localparam cnt_t LAT_C = cnt_t'(LATENCY);

  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic                  access_s;
  logic                  mis_s;
  logic                  ram_we_s;
  logic [IDX_W-1:0]      ram_addr_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;
  logic                  unused_addr_s;

  // Byte lane and bits above the word index never reach the RAM.
  assign unused_addr_s = ^{addr[31:IDX_W+2], addr[1:0]};

  assign access_s = (state_q == WAIT) && (cnt_q == cnt_t'(1'b0));
  assign ram_we_s = access_s && we_q && !mis_s;
  // In IDLE the RAM pre-reads the incoming address so LATENCY=0 still has data at the access edge.
  assign ram_addr_s = (state_q == IDLE) ? addr[IDX_W+1:2] : idx_q;

  ram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata_s)
  );

  // State, counter, request capture and read-result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= cnt_t'(1'b0);
      we_q        <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      read_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

  // Next-state, wait countdown and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = LAT_C;
          we_d    = we;
          idx_d   = addr[IDX_W+1:2];
          wdata_d = write_data;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == cnt_t'(1'b0)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - cnt_t'(1'b1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read result only moves on a completing, non-faulted read.
  always_comb begin
    if (access_s && !we_q && !mis_s) begin
      read_data_d = ram_rdata_s;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // Handshake outputs decoded directly from the state register.
  always_comb begin
    busy = 1'b0;
    ack  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        ack  = 1'b0;
      end
      WAIT: begin
        busy = 1'b1;
        ack  = 1'b0;
      end
      RESP: begin
        busy = 1'b1;
        ack  = 1'b1;
      end
      default: begin
        busy = 1'b0;
        ack  = 1'b0;
      end
    endcase
  end

  assign read_data = read_data_q;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic err_q, err_d;

  // Misalignment flag captured with the request; err pulses with the ack.
  always_comb begin
    if ((state_q == IDLE) && req) begin
      mis_d = (addr[1:0] != 2'b00);
    end else begin
      mis_d = mis_q;
    end
    err_d = access_s && mis_q;
  end

  // Alignment-check registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  assign mis_s = mis_q;
  assign err   = err_q;
`else
  assign mis_s = 1'b0;
  assign err   = 1'b0;
`endif

endmodule
